spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Receive front-end inside vga_top, directly downstream of the external SPI pins CS, SCK and MOSI.
- Oversamples the asynchronous SPI mode-0 bus in the system clock domain and assembles MSB-first bytes.
- Buffers bytes in a small FIFO and hands them to the command/control logic over a valid/ready interface.
- Flags framing errors and FIFO overflow.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser depth for CS/SCK/MOSI; minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- CS  input  1  SPI chip select, active low, asynchronous to clk.
- SCK  input  1  SPI clock, idle low, asynchronous to clk.
- MOSI  input  1  SPI data, master to slave.
- m_data  output  8  FIFO head byte.
- m_valid  output  1  high when the FIFO is non-empty.
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- frame_err  output  1  one-cycle pulse: CS deasserted mid-byte.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- busy  output  1  synchronised CS is low (frame in progress).

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - Synchroniser chains: CS chain to 1; SCK and MOSI chains to 0.
  - Shift register and bit_cnt to 0; FIFO emptied, so pointers and count are 0.
  - m_data = 0, m_valid = 0, frame_err = 0, overflow = 0, busy = 0.
  - Reset mid-byte discards the partial byte and all buffered bytes; no frame_err is raised.
- Synchronisation:
  - CS, SCK and MOSI each pass through SYNC_STAGES flops of equal depth, so sampled MOSI stays aligned with the detected SCK edge.
  - Edge detect uses one extra flop on synchronised SCK and CS.
- Input timing requirement: SCK high and low times of at least 3 clk periods each, and MOSI stable at least 2 clk periods before the SCK rise.
- FSM states:
  - IDLE: synchronised CS high.
  - ACTIVE: synchronised CS low.
- FSM transitions:
  - IDLE to ACTIVE on the CS falling edge; bit_cnt cleared on entry.
  - ACTIVE to IDLE on the CS rising edge.
- Sampling rule (ACTIVE only):
  - On each detected SCK rising edge: shift = {shift[6:0], mosi_s}; bit_cnt increments modulo 8.
  - On the edge where bit_cnt goes 7 to 0, the completed byte is pushed into the FIFO in the next cycle.
  - Multiple bytes per CS frame are allowed.
- SCK edges in IDLE are ignored.
- CS rising edge with bit_cnt != 0:
  - Partial byte discarded, no push.
  - frame_err pulses high for exactly 1 cycle; bit_cnt cleared.
- Latency: m_valid rises 2 clk cycles after the cycle the 8th SCK rising edge is detected, assuming the FIFO was empty. No bypass path.
- FIFO:
  - m_data always reflects the head entry, or 0 when empty.
  - A pop occurs when m_valid && m_ready.
  - Push while full with no simultaneous pop: byte dropped and overflow set to 1; overflow clears only on reset.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop is ignored (m_valid = 0), push is accepted.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- busy equals inverted synchronised CS, so it lags the pin by SYNC_STAGES cycles.

Test Plan:
- Reset: hold rst_n low for 4 cycles with CS=1 -> m_valid=0, m_data=0, frame_err=0, overflow=0, busy=0.
- Single byte: send 0x02 (CS low, 8 SCK pulses of 10 clk high/low, MSB first) -> m_valid=1 with m_data=0x02; one m_ready cycle -> m_valid=0.
- Fill and overflow: send 0xA5, 0x3C, 0xFF, 0x00, 0x81 with m_ready=0 -> four bytes held in order, 0x81 dropped, overflow=1; then drain with m_ready=1 -> 0xA5, 0x3C, 0xFF, 0x00, then m_valid=0.
- Framing error: CS low, 3 SCK pulses, CS high -> exactly one frame_err pulse, no push; a following 0x55 is received as 0x55.
- Full with simultaneous push/pop: FIFO full, m_ready=1 held during the cycle a new byte 0x7E pushes -> overflow stays 0; 0x7E appears as the last entry.
- Reset mid-byte and idle noise: pulse rst_n low after 4 bits of 0xF0 -> FIFO empty, next 0x0F received correctly; toggling SCK with CS high -> no push.

Source files
------------

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// Receive front-end for the SPI command port of vga_top. The SPI mode-0 pins
// arrive asynchronously to clk and are oversampled in the clk domain. Bytes are
// assembled MSB first and placed in a small FIFO. The FIFO hands them to the
// command/control logic over a valid/ready interface.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   CS         SPI chip select (active low, asynchronous)
//   SCK        SPI clock (idle low, asynchronous)
//   MOSI       SPI data, master to slave (asynchronous)
//   m_data     FIFO head byte, 0 when the FIFO is empty
//   m_valid    FIFO non-empty
//   m_ready    consumer accepts m_data when m_valid && m_ready
//   frame_err  one-cycle pulse when CS rises in the middle of a byte
//   overflow   sticky flag: a completed byte was dropped on a full FIFO
//   busy       synchronised CS is low (frame in progress)
// -----------------------------------------------------------------------------
module spi_slave_rx #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       CS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Synchronisers and edge detection
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic [SYNC_STAGES-1:0] sck_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   cs_d_r;
   logic                   sck_d_r;
   logic                   busy_r;

   logic cs_s;
   logic sck_s;
   logic mosi_s;
   logic sck_rise_s;
   logic cs_fall_s;
   logic cs_rise_s;

   // Equal-depth synchronisers keep MOSI aligned with the detected SCK edge.
   // busy is taken from the stage before the last one so that the registered
   // flag tracks the synchronised CS exactly, without an extra cycle of lag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_sync_r   <= {SYNC_STAGES{1'b1}};
         sck_sync_r  <= {SYNC_STAGES{1'b0}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         cs_d_r      <= 1'b1;
         sck_d_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
         sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
         cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
         sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
         busy_r      <= ~cs_sync_r[SYNC_STAGES-2];
      end
   end

   assign cs_s       = cs_sync_r[SYNC_STAGES-1];
   assign sck_s      = sck_sync_r[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
   assign sck_rise_s = sck_s & ~sck_d_r;
   assign cs_fall_s  = ~cs_s & cs_d_r;
   assign cs_rise_s  = cs_s & ~cs_d_r;

   // ------------------------------------------------------------------------
   // Frame FSM and byte assembly
   // ------------------------------------------------------------------------
   state_t     state_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] shift_r;
   logic [7:0] byte_r;
   logic       push_r;
   logic       frame_err_r;

   // Frame FSM: shifts on synchronised SCK rises while CS is low. It requests
   // a FIFO push one cycle after the eighth bit and flags CS rising mid-byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         byte_r      <= 8'h00;
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cs_fall_s) begin
                  state_r   <= ST_ACTIVE;
                  bit_cnt_r <= 3'd0;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise_s) begin
                  // The partial byte stays in shift_r, but it is never pushed.
                  state_r   <= ST_IDLE;
                  bit_cnt_r <= 3'd0;
                  if (bit_cnt_r != 3'd0) begin
                     frame_err_r <= 1'b1;
                  end else begin
                     frame_err_r <= 1'b0;
                  end
               end else if (sck_rise_s) begin
                  shift_r   <= {shift_r[6:0], mosi_s};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     byte_r <= {shift_r[6:0], mosi_s};
                     push_r <= 1'b1;
                  end else begin
                     push_r <= 1'b0;
                  end
               end else begin
                  state_r <= ST_ACTIVE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               bit_cnt_r <= 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------------
   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [7:0]       m_data_r;
   logic             m_valid_r;
   logic             overflow_r;

   logic             pop_s;
   logic             full_s;
   logic             wr_en_s;
   logic             ovf_set_s;
   logic [PTR_W-1:0] rd_ptr_next_s;
   logic [CNT_W-1:0] remain_s;
   logic [CNT_W-1:0] count_next_s;
   logic [7:0]       head_next_s;

   // Next-state FIFO bookkeeping. A pop frees a slot for a push in the same
   // cycle, so a full FIFO still accepts a byte when the consumer pops.
   // head_next_s is the byte m_data shows after this edge. It is the pushed
   // byte when the FIFO is left empty by this cycle's pop, or empty before it.
   always_comb begin
      pop_s     = m_valid_r & m_ready;
      full_s    = (count_r == CNT_FULL);
      wr_en_s   = push_r & (~full_s | pop_s);
      ovf_set_s = push_r & full_s & ~pop_s;

      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PTR_ONE;
         remain_s      = count_r - CNT_ONE;
      end else begin
         rd_ptr_next_s = rd_ptr_r;
         remain_s      = count_r;
      end

      if (wr_en_s) begin
         count_next_s = remain_s + CNT_ONE;
      end else begin
         count_next_s = remain_s;
      end

      if (count_next_s == CNT_ZERO) begin
         head_next_s = 8'h00;
      end else if (remain_s == CNT_ZERO) begin
         head_next_s = byte_r;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // FIFO storage, pointers, registered head/valid and the sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= CNT_ZERO;
         m_data_r   <= 8'h00;
         m_valid_r  <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= byte_r;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r  <= rd_ptr_next_s;
         count_r   <= count_next_s;
         m_data_r  <= head_next_s;
         m_valid_r <= (count_next_s != CNT_ZERO);
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign m_data    = m_data_r;
   assign m_valid   = m_valid_r;
   assign frame_err = frame_err_r;
   assign overflow  = overflow_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Drives SPI mode-0 frames into spi_slave_rx. A queue-based reference model
// predicts the FIFO contents, m_data/m_valid, overflow and busy every cycle.
// Directed scenarios cover reset, a single byte, overflow, framing errors,
// push/pop while full, reset mid-byte and idle noise. A randomized phase
// follows with random bytes, SCK timing and consumer readiness.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

   localparam int DEPTH = 4;
   localparam int SS    = 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       cs      = 1'b1;
   logic       sck     = 1'b0;
   logic       mosi    = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       frame_err;
   logic       overflow;
   logic       busy;

   spi_slave_rx #(
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (SS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .CS        (cs),
      .SCK       (sck),
      .MOSI      (mosi),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Counters.
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model. Bytes enter the queue SS+2 cycles after the bench
   // drives their eighth SCK rise. The queue holds at most DEPTH bytes.
   int         cyc = 0;
   logic [7:0] mq[$];
   int         due_q[$];
   logic [7:0] pend_q[$];
   logic       ovf_m   = 1'b0;
   logic [SS-1:0] cs_hist = {SS{1'b1}};
   int         fe_cnt  = 0;
   int         fe_exp  = 0;
   bit         pop_m;
   logic [7:0] b_m;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         mq.delete();
         due_q.delete();
         pend_q.delete();
         ovf_m   = 1'b0;
         cs_hist = {SS{1'b1}};
      end else begin
         pop_m = (mq.size() > 0) && m_ready;
         if (pop_m) void'(mq.pop_front());
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            b_m = pend_q.pop_front();
            if (mq.size() == DEPTH) ovf_m = 1'b1;
            else mq.push_back(b_m);
         end
         cs_hist = {cs_hist[SS-2:0], cs};
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("m_valid", m_valid, mq.size() > 0);
      chk("m_data", m_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("overflow", overflow, ovf_m);
      chk("busy", busy, !cs_hist[SS-1]);
      if (frame_err === 1'b1) fe_cnt++;
   end

   bit rand_ready = 1'b0;
   always @(negedge clk) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #800000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------- drivers
   int bits_in_frame = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_start();
      cs = 1'b0;
      bits_in_frame = 0;
      tick(4);
   endtask

   task automatic frame_end(input int half);
      tick(half);
      cs = 1'b1;
      if (bits_in_frame % 8 != 0) fe_exp++;
      bits_in_frame = 0;
      tick(8);
   endtask

   // One SCK period. sched records a completed byte in the model. rdy_pulse
   // raises m_ready for exactly the cycle that byte reaches the FIFO.
   task automatic send_bit(input logic b, input int half, input bit sched,
                           input logic [7:0] byte_val, input bit rdy_pulse);
      int due;
      mosi = b;
      tick(half);
      sck = 1'b1;
      bits_in_frame++;
      due = cyc + SS + 2;
      if (sched) begin
         due_q.push_back(due);
         pend_q.push_back(byte_val);
      end
      for (int i = 0; i < half; i++) begin
         @(negedge clk);
         if (rdy_pulse) m_ready = (cyc == due - 1);
      end
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int half, input bit rdy_pulse);
      for (int i = 7; i >= 0; i--) begin
         send_bit(v[i], half, i == 0, v, rdy_pulse && (i == 0));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(2);
   endtask

   // ---------------------------------------------------------------- tests
   logic [7:0] fill_v [5];
   logic [7:0] exp_v  [4];
   logic [7:0] rb;
   int         fe_before;
   int         nb;
   int         half;
   int         guard;

   initial begin
      // Reset.
      rst_n = 1'b0;
      tick(4);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_data", m_data, 8'h00);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick(4);

      // Single byte.
      frame_start();
      chk("busy_in_frame", busy, 1'b1);
      send_byte(8'h02, 10, 1'b0);
      frame_end(10);
      chk("single_valid", m_valid, 1'b1);
      chk("single_data", m_data, 8'h02);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      chk("single_popped", m_valid, 1'b0);

      // Fill and overflow.
      fill_v = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
      frame_start();
      for (int k = 0; k < 5; k++) send_byte(fill_v[k], 10, 1'b0);
      frame_end(10);
      chk("fill_overflow", overflow, 1'b1);
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("fill_drain", m_data, fill_v[k]);
         tick(1);
      end
      m_ready = 1'b0;
      chk("fill_empty", m_valid, 1'b0);

      // Framing error followed by a clean byte.
      fe_before = fe_cnt;
      frame_start();
      send_bit(1'b1, 10, 1'b0, 8'h00, 1'b0);
      send_bit(1'b0, 10, 1'b0, 8'h00, 1'b0);
      send_bit(1'b1, 10, 1'b0, 8'h00, 1'b0);
      frame_end(10);
      chk("frame_err_pulse", fe_cnt - fe_before, 1);
      chk("frame_err_nopush", m_valid, 1'b0);
      frame_start();
      send_byte(8'h55, 10, 1'b0);
      frame_end(10);
      chk("after_ferr_data", m_data, 8'h55);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int k = 0; k < 4; k++) fill_v[k] = 8'($urandom);
      frame_start();
      for (int k = 0; k < 4; k++) send_byte(fill_v[k], 10, 1'b0);
      send_byte(8'h7E, 10, 1'b1);
      frame_end(10);
      chk("pushpop_no_ovf", overflow, 1'b0);
      exp_v = '{fill_v[1], fill_v[2], fill_v[3], 8'h7E};
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("pushpop_drain", m_data, exp_v[k]);
         tick(1);
      end
      m_ready = 1'b0;
      chk("pushpop_empty", m_valid, 1'b0);

      // Reset mid-byte discards the buffered byte and the partial one.
      frame_start();
      send_byte(8'h99, 10, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 10, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      cs = 1'b1;
      bits_in_frame = 0;
      tick(8);
      chk("midreset_empty", m_valid, 1'b0);
      frame_start();
      send_byte(8'h0F, 10, 1'b0);
      frame_end(10);
      chk("midreset_next", m_data, 8'h0F);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;

      // SCK noise with CS high.
      for (int i = 0; i < 10; i++) begin
         sck = 1'b1; tick(4);
         sck = 1'b0; tick(4);
      end
      tick(6);
      chk("noise_no_push", m_valid, 1'b0);

      // Randomized frames.
      rand_ready = 1'b1;
      for (int f = 0; f < 10; f++) begin
         half = $urandom_range(3, 8);
         nb   = $urandom_range(1, 3);
         frame_start();
         for (int k = 0; k < nb; k++) begin
            rb = 8'($urandom);
            send_byte(rb, half, 1'b0);
         end
         if ($urandom_range(0, 3) == 0) begin
            guard = $urandom_range(1, 7);
            for (int i = 0; i < guard; i++) begin
               send_bit(1'($urandom), half, 1'b0, 8'h00, 1'b0);
            end
         end
         frame_end(half);
      end
      rand_ready = 1'b0;
      m_ready = 1'b1;
      guard = 0;
      while (m_valid === 1'b1 && guard < 20) begin
         tick(1);
         guard++;
      end
      m_ready = 1'b0;
      chk("rand_drained", m_valid, 1'b0);
      chk("frame_err_total", fe_cnt, fe_exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
